pc_fetch_unit: RTL

//  Program-counter and instruction-fetch stage of the Proyecto4 datapath.

---
 rtl/pc_fetch_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter and instruction-fetch stage. Holds the fetch PC, issues
// req/ack reads to instruction memory and presents the fetched instruction
// together with its address to decode/execute. The pc output also feeds the
// operand-B select as the PC-relative ALU source.
//
// Handles downstream stall, single-cycle branch redirects and squashing of
// fetches that are in flight when a redirect arrives.
//
// Build option:
//   MISALIGN_TRAP_EN  defined   : a branch target with target[1:0] != 0 is
//                                 replaced by TRAP_VECTOR and misalign_err
//                                 pulses for one cycle.
//                     undefined : target[1:0] is forced to 2'b00 and
//                                 misalign_err is always 0.
//
// Ports:
//   clk            in   1   single clock, all state on rising edge
//   rst            in   1   synchronous, active-high reset
//   stall          in   1   downstream not ready; hold current instr
//   branch_taken   in   1   redirect request, single-cycle pulse
//   branch_target  in   32  redirect address, valid with branch_taken
//   imem_req       out  1   fetch request to instruction memory
//   imem_addr      out  32  fetch address, stable while imem_req=1
//   imem_ack       in   1   read complete; imem_rdata valid this cycle
//   imem_rdata     in   32  instruction word
//   instr          out  32  fetched instruction
//   instr_valid    out  1   instr/pc valid; consumed when instr_valid & ~stall
//   pc             out  32  address of instr
//   misalign_err   out  1   one-cycle pulse on misaligned branch target
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
`ifdef MISALIGN_TRAP_EN
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
`endif
  parameter int unsigned PC_STEP      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic        r_redirect_pend;
  logic [31:0] r_target;
  logic        r_imem_req;
  logic [31:0] r_imem_addr;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic [31:0] r_pc;
  logic        r_misalign_err;

  logic        w_misaligned;
  logic [31:0] w_branch_dest;
  logic [31:0] w_redirect_dest;
  logic [31:0] w_seq_pc;

`ifdef MISALIGN_TRAP_EN
  assign w_misaligned  = |branch_target[1:0];
  assign w_branch_dest = w_misaligned ? TRAP_VECTOR : branch_target;
`else
  assign w_misaligned  = 1'b0;
  assign w_branch_dest = branch_target & ~32'h0000_0003;
`endif

  // A fresh branch this cycle takes priority over a redirect latched earlier
  // while the fetch was still waiting for its ack.
  assign w_redirect_dest = branch_taken ? w_branch_dest : r_target;

  // Wraps modulo 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
  assign w_seq_pc = r_fetch_pc + 32'(PC_STEP);

  // NOTE: reset is sampled on the clock edge only (synchronous); an ack that
  // arrives while rst is high therefore never reaches the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_RST;
      r_fetch_pc      <= RESET_VECTOR;
      r_redirect_pend <= 1'b0;
      r_target        <= RESET_VECTOR;
      r_imem_req      <= 1'b0;
      r_imem_addr     <= RESET_VECTOR;
      r_instr         <= 32'h0;
      r_instr_valid   <= 1'b0;
      r_pc            <= RESET_VECTOR;
      r_misalign_err  <= 1'b0;
    end else begin
      // NOTE: every state register uses non-blocking assignment so all of
      // them update together from the values seen before this edge.
      // Branches are ignored in S_RST, so no error pulse can start there.
      r_misalign_err <= branch_taken && w_misaligned && (r_state != S_RST);

      case (r_state)
        S_RST: begin
          r_state     <= S_FETCH;
          r_imem_req  <= 1'b1;
          r_imem_addr <= r_fetch_pc;
        end

        S_FETCH: begin
          if (imem_ack) begin
            if (branch_taken || r_redirect_pend) begin
              // Returned word belongs to the wrong path: drop it and
              // re-issue the request at the redirect address.
              r_fetch_pc      <= w_redirect_dest;
              r_imem_addr     <= w_redirect_dest;
              r_redirect_pend <= 1'b0;
            end else begin
              r_instr       <= imem_rdata;
              r_pc          <= r_fetch_pc;
              r_instr_valid <= 1'b1;
              r_fetch_pc    <= w_seq_pc;
              r_imem_req    <= 1'b0;
              r_state       <= S_VALID;
            end
          end else if (branch_taken) begin
            // The request must stay stable until acked, so only remember
            // where to go once the in-flight read completes.
            r_redirect_pend <= 1'b1;
            r_target        <= w_branch_dest;
          end
        end

        S_VALID: begin
          if (branch_taken) begin
            // Squash the presented instruction even if downstream stalls.
            r_instr_valid <= 1'b0;
            r_fetch_pc    <= w_branch_dest;
            r_imem_req    <= 1'b1;
            r_imem_addr   <= w_branch_dest;
            r_state       <= S_FETCH;
          end else if (!stall) begin
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
            r_imem_addr   <= r_fetch_pc;
            r_state       <= S_FETCH;
          end
        end

        default: begin
          r_state <= S_RST;
        end
      endcase
    end
  end

  assign imem_req     = r_imem_req;
  assign imem_addr    = r_imem_addr;
  assign instr        = r_instr;
  assign instr_valid  = r_instr_valid;
  assign pc           = r_pc;
  assign misalign_err = r_misalign_err;

endmodule
